// File: rtl/radar_filter_pkg.sv
// Purpose: shared types and sizing for the radar noise-reducer median path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package radar_filter_pkg;

  // Default sample width and median window length for the noise reducer.
  localparam int RADAR_DATA_W = 32;
  localparam int MEDIAN_WIN   = 5;

  // One signed radar sample, carried bit-exact through the feeder.
  typedef logic signed [RADAR_DATA_W-1:0] radar_sample_t;

  // A full median window: [0] oldest ... [MEDIAN_WIN-1] newest.
  typedef radar_sample_t median_window_t [0:MEDIAN_WIN-1];

endpackage : radar_filter_pkg

// File: rtl/median_window_feeder.sv
// Purpose: turns a framed sample stream into stride-1 sliding WIN-sample windows.
// Latency: a window is presented 1 cycle after the sample that completes it is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a stalled window holds still.
module median_window_feeder
  import radar_filter_pkg::*;
#(
  parameter int DATA_W = RADAR_DATA_W,
  parameter int WIN    = MEDIAN_WIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] window_out [0:WIN-1],
  output logic                     out_last,
  output logic                     frame_short
);

  // Fill counter counts 0..WIN and saturates; it is the only thing that
  // decides whether the window registers hold a complete current-frame window.
  localparam int                FILL_W    = $clog2(WIN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN);

  logic signed [DATA_W-1:0] win_q [0:WIN-1];
  logic signed [DATA_W-1:0] win_d [0:WIN-1];
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     frame_short_q, frame_short_d;

  logic                     accept;
  logic                     out_take;
  logic [FILL_W-1:0]        fill_next;

  // Handshake terms: accept whenever the output slot is empty or being drained.
  always_comb begin
    in_ready  = !out_valid_q || out_ready;
    accept    = in_valid && in_ready;
    out_take  = out_valid_q && out_ready;
    fill_next = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
  end

  // Next state: shift on accept, publish a window once the frame has WIN samples,
  // end the frame on in_last (reporting a short frame if no window was produced).
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      win_d[i] = win_q[i];
    end
    fill_d        = fill_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_short_d = 1'b0;

    // A drained window empties the slot unless a new one loads below.
    if (out_take) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int i = 0; i < WIN - 1; i++) begin
        win_d[i] = win_q[i + 1];
      end
      win_d[WIN-1] = in_data;

      if (fill_next == FILL_FULL) begin
        out_valid_d = 1'b1;
        out_last_d  = in_last;
      end else if (in_last) begin
        frame_short_d = 1'b1;
      end

      // Window regs are left dirty at frame end; the cleared fill keeps stale
      // samples from ever reaching a published window.
      fill_d = in_last ? '0 : fill_next;
    end
  end

  // State registers with synchronous reset; a reset drops any partial frame silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
      fill_q        <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_short_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= win_d[i];
      end
      fill_q        <= fill_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_short_q <= frame_short_d;
    end
  end

  // Outputs come straight from registers so the median stage sees clean timing.
  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      window_out[i] = win_q[i];
    end
    out_valid   = out_valid_q;
    out_last    = out_last_q;
    frame_short = frame_short_q;
  end

endmodule : median_window_feeder
